// File: rtl/pp_serial_cpa_pkg.sv
// Shared definitions for the partial-product resolution blocks: default row
// geometry and the encoding of the serial carry-propagate adder FSM.
package pp_serial_cpa_pkg;

  localparam int CPA_SUM_W       = 28;
  localparam int CPA_CARRY_W     = 25;
  localparam int CPA_CARRY_SHIFT = 3;
  localparam int CPA_SEG_W       = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } cpa_state_e;

endpackage

// File: rtl/seg_adder.sv
// One segment of the serial carry-propagate adder: a plain SEG_W-bit add
// with carry in and carry out.
module seg_adder
  import pp_serial_cpa_pkg::*;
#(
  parameter int SEG_W = CPA_SEG_W
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/pp_serial_cpa.sv
// Resolves a sum/carry row pair into a binary result, one SEG_W segment per
// cycle, with a valid/ready handshake on both sides.
module pp_serial_cpa
  import pp_serial_cpa_pkg::*;
#(
  parameter int SUM_W       = CPA_SUM_W,
  parameter int CARRY_W     = CPA_CARRY_W,
  parameter int CARRY_SHIFT = CPA_CARRY_SHIFT,
  parameter int SEG_W       = CPA_SEG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUM_W-1:0]   sum_row,
  input  logic [CARRY_W-1:0] carry_row,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUM_W-1:0]   result
);

  localparam int NSEG   = SUM_W / SEG_W;
  localparam int SEG_CW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int EXT_W  = SUM_W + CARRY_W + CARRY_SHIFT;
  localparam logic [SEG_CW-1:0] SEG_LAST = SEG_CW'(NSEG - 1);

  cpa_state_e                   state, state_nxt;
  logic [SEG_CW-1:0]            seg;
  logic                         carry;
  logic                         ready_en;
  logic [SUM_W-1:0]             sum_cap;
  logic [CARRY_W-1:0]           carry_cap;
  logic [NSEG-1:0][SEG_W-1:0]   res_segs;

  logic [EXT_W-1:0]             carry_ext;
  logic [NSEG-1:0][SEG_W-1:0]   sum_segs;
  logic [NSEG-1:0][SEG_W-1:0]   carry_segs;
  logic [SEG_W-1:0]             seg_s;
  logic                         seg_co;
  logic                         accept;

  // Carry row aligned to sum weights; bits landing at or above SUM_W are dropped.
  assign carry_ext  = {{(SUM_W + CARRY_SHIFT){1'b0}}, carry_cap} << CARRY_SHIFT;
  assign sum_segs   = sum_cap;
  assign carry_segs = carry_ext[SUM_W-1:0];

  seg_adder #(
    .SEG_W (SEG_W)
  ) u_seg_adder (
    .a    (sum_segs[seg]),
    .b    (carry_segs[seg]),
    .cin  (carry),
    .s    (seg_s),
    .cout (seg_co)
  );

  // ready_en keeps in_ready low during reset and until the first edge after it.
  assign in_ready  = ready_en && (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = res_segs;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept)            state_nxt = ST_ADD;
      ST_ADD:  if (seg == SEG_LAST)   state_nxt = ST_DONE;
      ST_DONE: if (out_ready)         state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      seg       <= '0;
      carry     <= 1'b0;
      ready_en  <= 1'b0;
      sum_cap   <= '0;
      carry_cap <= '0;
      res_segs  <= '0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            sum_cap   <= sum_row;
            carry_cap <= carry_row;
            seg       <= '0;
            carry     <= 1'b0;
          end
        end
        ST_ADD: begin
          res_segs[seg] <= seg_s;
          carry         <= seg_co;
          seg           <= (seg == SEG_LAST) ? '0 : seg + SEG_CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pp_serial_cpa.sv
// Self-checking bench for pp_serial_cpa: directed corner cases, backpressure,
// mid-operation reset and randomized back-to-back traffic against a scoreboard.
module tb_pp_serial_cpa;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] sum_row;
  logic [24:0] carry_row;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] result;

  int tests = 0;
  int fails = 0;
  logic [27:0] exp_q[$];

  pp_serial_cpa dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_row   (sum_row),
    .carry_row (carry_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [27:0] model(input logic [27:0] s, input logic [24:0] c);
    logic [63:0] t;
    t = {36'd0, s} + ({39'd0, c} << 3);
    return t[27:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [27:0] s, input logic [24:0] c);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    sum_row   = s;
    carry_row = c;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (ok) begin
      exp_q.push_back(model(s, c));
      @(posedge clk);
      #1;
    end else begin
      chk("send_timeout", 32'(ok), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    bit got;
    got = 1'b0;
    cnt = 0;
    while (cnt < 20 && !got) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else cnt++;
    end
    chk("out_valid_timeout", 32'(got), 32'd1);
  endtask

  task automatic finish_txn(input bit chk_lat, input int cnt, input int hold, input bit compete);
    logic [27:0] exp;
    if (chk_lat) chk("latency", cnt, 32'd4);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 'x;
    chk("result", 32'(result), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (compete) begin
        in_valid  = 1'b1;
        sum_row   = 28'h5A5A5A5;
        carry_row = 25'h1234567;
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_result", 32'(result), 32'(exp));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int cnt;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_row   = '0;
    carry_row = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);

    // Directed adds
    send(28'h0000001, 25'h0000001);
    wait_valid(cnt);
    finish_txn(1'b1, cnt, 0, 1'b0);

    send(28'hFFFFFFF, 25'h0000001);
    wait_valid(cnt);
    finish_txn(1'b1, cnt, 0, 1'b0);

    send(28'h0000000, 25'h1FFFFFF);
    wait_valid(cnt);
    finish_txn(1'b1, cnt, 0, 1'b0);

    send(28'hFFFFFFF, 25'h1FFFFFF);
    wait_valid(cnt);
    finish_txn(1'b1, cnt, 0, 1'b0);

    // Backpressure with a competing request
    send(28'h0ABCDEF, 25'h1555555);
    wait_valid(cnt);
    finish_txn(1'b1, cnt, 5, 1'b1);
    expect_quiet("no_resample_after_bp", 8);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of ADD at seg=2
    send(28'h1234567, 25'h0ABCDEF);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_back", 32'(in_ready), 32'd1);
    expect_quiet("midrst_no_valid", 8);
    send(28'h7654321, 25'h0FEDCBA);
    wait_valid(cnt);
    finish_txn(1'b1, cnt, 0, 1'b0);

    // Random back-to-back traffic with gaps
    for (int n = 0; n < 3000; n++) begin
      logic [27:0] rs;
      logic [24:0] rc;
      rs = 28'($urandom());
      rc = 25'($urandom());
      if (n % 7 == 0) rs = 28'hFFFFFFF;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rs, rc);
      wait_valid(cnt);
      finish_txn(1'b1, cnt, int'($urandom_range(0, 2)), 1'b0);
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
